// File: rtl/clock_time_setter_pkg.sv
// Shared definitions for the intersection time setter: state encodings, field limits and
// the per-state range check.
package clock_time_setter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_HOUR = 3'd1,
    ST_GET_MIN  = 3'd2,
    ST_GET_SEC  = 3'd3,
    ST_GET_AMPM = 3'd4,
    ST_LOAD     = 3'd5
  } state_e;

  localparam logic [5:0] HOUR_MIN   = 6'd1;
  localparam logic [5:0] HOUR_MAX   = 6'd12;
  localparam logic [5:0] MINSEC_MAX = 6'd59;
  localparam logic       AM         = 1'b0;
  localparam logic       PM         = 1'b1;

  // Unsigned compare on the full 6-bit value, so hour bits [5:4] must be zero.
  function automatic logic field_ok(input state_e st, input logic [5:0] v);
    case (st)
      ST_GET_HOUR:            return (v >= HOUR_MIN) && (v <= HOUR_MAX);
      ST_GET_MIN, ST_GET_SEC: return v <= MINSEC_MAX;
      ST_GET_AMPM:            return v <= 6'd1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/clock_time_setter_if.sv
// Load port from the time setter to the intersection clock block (valid/ready handshake
// carrying a complete time of day).
interface clock_time_setter_if;
  logic       loadValid;
  logic       loadReady;
  logic [3:0] loadHour;
  logic [5:0] loadMinute;
  logic [5:0] loadSecond;
  logic       loadAmPm;

  modport master (output loadValid, loadHour, loadMinute, loadSecond, loadAmPm,
                  input  loadReady);
  modport slave  (input  loadValid, loadHour, loadMinute, loadSecond, loadAmPm,
                  output loadReady);
endinterface

// File: rtl/clock_time_setter_action_edge.sv
// Registers the action button once and emits a single-cycle pulse on each 0->1 transition.
module clock_time_setter_action_edge (
  input  logic clk,
  input  logic rst,
  input  logic action,
  output logic act_pulse
);

  logic action_d, action_q;

  always_comb action_d = action;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) action_q <= 1'b0;
    else     action_q <= action_d;
  end

  assign act_pulse = action & ~action_q;

endmodule

// File: rtl/clock_time_setter.sv
// Operator time-of-day entry: collects hour/minute/second/AM-PM with range checks, then
// presents the whole time on the load handshake to the clock block.
module clock_time_setter
  import clock_time_setter_pkg::*;
#(
  parameter int RST_HOUR = 12,
  parameter int RST_AMPM = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       setReq,
  input  logic [5:0]                 valueIn,
  input  logic                       action,
  input  logic                       abort,
  output logic [2:0]                 setPhase,
  output logic                       entryError,
  output logic                       busy,
  clock_time_setter_if.master        load_if
);

  localparam logic [3:0] RST_HOUR_V = 4'(RST_HOUR);
  localparam logic       RST_AMPM_V = 1'(RST_AMPM);

  state_e     state_q, state_d;
  logic [3:0] stg_hour_q, stg_hour_d;
  logic [5:0] stg_min_q, stg_min_d;
  logic [5:0] stg_sec_q, stg_sec_d;
  logic [3:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       ampm_q, ampm_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       act_pulse;

  clock_time_setter_action_edge u_action_edge (
    .clk       (clk),
    .rst       (rst),
    .action    (action),
    .act_pulse (act_pulse)
  );

  always_comb begin
    state_d    = state_q;
    stg_hour_d = stg_hour_q;
    stg_min_d  = stg_min_q;
    stg_sec_d  = stg_sec_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    ampm_d     = ampm_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (setReq) begin
          state_d = ST_GET_HOUR;
          err_d   = 1'b0;
        end
      end
      ST_GET_HOUR, ST_GET_MIN, ST_GET_SEC, ST_GET_AMPM: begin
        // abort takes priority over a simultaneous button press
        if (abort) begin
          state_d = ST_IDLE;
        end else if (act_pulse && !field_ok(state_q, valueIn)) begin
          err_d = 1'b1;
        end else if (act_pulse) begin
          err_d = 1'b0;
          case (state_q)
            ST_GET_HOUR: begin stg_hour_d = valueIn[3:0]; state_d = ST_GET_MIN;  end
            ST_GET_MIN:  begin stg_min_d  = valueIn;      state_d = ST_GET_SEC;  end
            ST_GET_SEC:  begin stg_sec_d  = valueIn;      state_d = ST_GET_AMPM; end
            default: begin
              hour_d  = stg_hour_q;
              min_d   = stg_min_q;
              sec_d   = stg_sec_q;
              ampm_d  = valueIn[0] ? PM : AM;
              state_d = ST_LOAD;
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (valid_q && load_if.loadReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stg_hour_q <= RST_HOUR_V;
      stg_min_q  <= 6'd0;
      stg_sec_q  <= 6'd0;
      hour_q     <= RST_HOUR_V;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      ampm_q     <= RST_AMPM_V;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stg_hour_q <= stg_hour_d;
      stg_min_q  <= stg_min_d;
      stg_sec_q  <= stg_sec_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      ampm_q     <= ampm_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign load_if.loadValid  = valid_q;
  assign load_if.loadHour   = hour_q;
  assign load_if.loadMinute = min_q;
  assign load_if.loadSecond = sec_q;
  assign load_if.loadAmPm   = ampm_q;
  assign setPhase           = state_q;
  assign entryError         = err_q;
  assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: directed scenarios plus random operator activity, all
// checked every cycle against a field-level reference model of the entry sequence.
module tb_clock_time_setter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       setReq = 1'b0;
  logic [5:0] valueIn = 6'd0;
  logic       action = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] setPhase;
  logic       entryError;
  logic       busy;

  clock_time_setter_if load_if();

  clock_time_setter #(.RST_HOUR(12), .RST_AMPM(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .setReq     (setReq),
    .valueIn    (valueIn),
    .action     (action),
    .abort      (abort),
    .setPhase   (setPhase),
    .entryError (entryError),
    .busy       (busy),
    .load_if    (load_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_vcyc = 0;

  // Model: phase 0 idle, 1..4 collecting field phase-1, 5 presenting the load.
  int m_phase, m_err, m_valid, m_act_prev;
  int m_stage[4];
  int m_out[4];
  int lo[4] = '{1, 0, 0, 0};
  int hi[4] = '{12, 59, 59, 1};

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_err = 0; m_valid = 0; m_act_prev = 0;
    m_out   = '{12, 0, 0, 0};
    m_stage = '{12, 0, 0, 0};
  endfunction

  function automatic void model_clock();
    int pulse, v, f;
    pulse = (action && !m_act_prev) ? 1 : 0;
    m_act_prev = action ? 1 : 0;
    v = int'(valueIn);
    if (m_phase == 0) begin
      if (setReq) begin m_phase = 1; m_err = 0; end
    end else if (m_phase == 5) begin
      if (load_if.loadReady) m_phase = 0;
    end else if (abort) begin
      m_phase = 0;
    end else if (pulse == 1) begin
      f = m_phase - 1;
      if (v >= lo[f] && v <= hi[f]) begin
        m_stage[f] = v;
        m_err = 0;
        if (f == 3) begin
          m_out = m_stage;
          m_phase = 5;
        end else begin
          m_phase = m_phase + 1;
        end
      end else begin
        m_err = 1;
      end
    end
    m_valid = (m_phase == 5) ? 1 : 0;
  endfunction

  task automatic compare_all();
    if (load_if.loadValid) n_vcyc++;
    chk("phase", int'(setPhase), m_phase);
    chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
    chk("valid", int'(load_if.loadValid), m_valid);
    chk("error", int'(entryError), m_err);
    chk("hour", int'(load_if.loadHour), m_out[0]);
    chk("minute", int'(load_if.loadMinute), m_out[1]);
    chk("second", int'(load_if.loadSecond), m_out[2]);
    chk("ampm", int'(load_if.loadAmPm), m_out[3]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
  endtask

  task automatic enter(input int v);
    valueIn = 6'(v);
    action = 1'b1;
    cyc();
    action = 1'b0;
    cyc();
  endtask

  initial begin
    load_if.loadReady = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("t1_valid", int'(load_if.loadValid), 0);
    chk("t1_hour", int'(load_if.loadHour), 12);

    // 7:30:15 AM with the receiver already ready
    setReq = 1'b1; cyc(); setReq = 1'b0;
    enter(7); enter(30); enter(15);
    load_if.loadReady = 1'b1;
    n_vcyc = 0;
    enter(0);
    cyc();
    chk("t2_pulse_cycles", n_vcyc, 1);
    chk("t2_busy", int'(busy), 0);
    chk("t2_minute", int'(load_if.loadMinute), 30);
    load_if.loadReady = 1'b0;

    // hour range errors
    setReq = 1'b1; cyc(); setReq = 1'b0;
    enter(13);
    chk("t3_err13", int'(entryError), 1);
    chk("t3_phase13", int'(setPhase), 1);
    enter(0);
    chk("t3_err0", int'(entryError), 1);
    enter(12);
    chk("t3_err12", int'(entryError), 0);
    chk("t3_phase12", int'(setPhase), 2);

    // LOAD holds through abort until ready
    enter(45); enter(59); enter(1);
    abort = 1'b1;
    repeat (5) cyc();
    chk("t4_valid_held", int'(load_if.loadValid), 1);
    chk("t4_hour_held", int'(load_if.loadHour), 12);
    abort = 1'b0;
    load_if.loadReady = 1'b1;
    cyc();
    chk("t4_idle", int'(setPhase), 0);
    load_if.loadReady = 1'b0;

    // held button accepts once, then abort discards
    setReq = 1'b1; cyc(); setReq = 1'b0;
    enter(3);
    valueIn = 6'd59; action = 1'b1;
    repeat (10) cyc();
    action = 1'b0; cyc();
    chk("t5_one_accept", int'(setPhase), 3);
    abort = 1'b1; cyc(); abort = 1'b0;
    chk("t5_aborted", int'(setPhase), 0);
    chk("t5_second_kept", int'(load_if.loadSecond), 59);

    // async reset in LOAD
    setReq = 1'b1; cyc(); setReq = 1'b0;
    enter(9); enter(8); enter(7); enter(1);
    chk("t6_in_load", int'(load_if.loadValid), 1);
    #2 rst = 1'b1;
    #1 chk("t6_async_valid", int'(load_if.loadValid), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("t6_phase", int'(setPhase), 0);

    // random operator activity
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       valueIn = 6'($urandom_range(0, 63));
        1:       valueIn = 6'($urandom_range(55, 62));
        default: valueIn = 6'($urandom_range(0, 13));
      endcase
      action = 1'($urandom_range(0, 1));
      setReq = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      load_if.loadReady = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
